mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : MAR/MDR memory responder: edge-detected Read/Write strobes,
//            WAIT_STATES wait cycles, internal RAM, one-cycle Ready pulse.
//            Optional out-of-range Fault flag when MEM_FAULT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] MAR_q,
    input  logic [31:0] MDR_q,
    output logic [31:0] Mdatain,
    output logic        Busy,
    output logic        Ready
`ifdef MEM_FAULT_EN
    ,
    output logic        Fault
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                req_prev_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                wr_q, wr_d;
    logic                oob_q, oob_d;
    logic [31:0]         mdat_q, mdat_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;

    logic [31:0]         ram_q [DEPTH];

    logic                w_req;
    logic                w_accept;
    logic                w_oob;
    logic                w_ram_we;

    assign w_req    = Read | Write;
    assign w_accept = (state_q == S_IDLE) && w_req && !req_prev_q;

`ifdef MEM_FAULT_EN
    assign w_oob = (MAR_q >= 32'(DEPTH));
`else
    assign w_oob = 1'b0;
    logic w_unused_mar;
    assign w_unused_mar = ^MAR_q[31:ADDR_W];
`endif

    // Clear coincident with the ACCESS edge must suppress the store.
    assign w_ram_we = (state_q == S_ACCESS) && wr_q && !oob_q && !Clear;

    always_ff @(posedge Clock) begin
        if (w_ram_we) begin
            ram_q[addr_q] <= data_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            req_prev_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            oob_q      <= 1'b0;
            mdat_q     <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_prev_q <= w_req;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            oob_q      <= oob_d;
            mdat_q     <= mdat_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        oob_d   = oob_q;
        mdat_d  = mdat_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    addr_d = MAR_q[ADDR_W-1:0];
                    data_d = MDR_q;
                    wr_d   = Write;
                    oob_d  = w_oob;
                    busy_d = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = c_WAIT_LOAD;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (!wr_q) begin
                    mdat_d = oob_q ? 32'd0 : ram_q[addr_q];
                end
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MEM_FAULT_EN
    logic fault_q;

    always_ff @(posedge Clock) begin
        if (Clear || w_accept) begin
            fault_q <= 1'b0;
        end else if (state_q == S_ACCESS) begin
            fault_q <= oob_q;
        end
    end

    assign Fault = fault_q;
`endif

    assign Mdatain = mdat_q;
    assign Busy    = busy_q;
    assign Ready   = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench; three responders (WAIT_STATES 0/1/3) share
//            stimulus and are compared against a per-instance memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

    localparam int DEPTH = 512;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        Read  = 1'b0;
    logic        Write = 1'b0;
    logic [31:0] MAR_q = 32'd0;
    logic [31:0] MDR_q = 32'd0;

    logic [31:0] mdat [3];
    logic        busy [3];
    logic        rdy  [3];
`ifdef MEM_FAULT_EN
    logic        flt  [3];
`endif

    int          ws_of [3] = '{0, 1, 3};
    logic [31:0] ref_mem [3][DEPTH];
    logic [31:0] exp_mdat [3];
    int          errors = 0;
    int          checks = 0;

    always #5 Clock = ~Clock;

    mem_responder #(.ADDR_W(9), .DEPTH(DEPTH), .WAIT_STATES(0)) d0 (
        .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write),
        .MAR_q(MAR_q), .MDR_q(MDR_q), .Mdatain(mdat[0]), .Busy(busy[0]),
        .Ready(rdy[0])
`ifdef MEM_FAULT_EN
        , .Fault(flt[0])
`endif
    );

    mem_responder #(.ADDR_W(9), .DEPTH(DEPTH), .WAIT_STATES(1)) d1 (
        .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write),
        .MAR_q(MAR_q), .MDR_q(MDR_q), .Mdatain(mdat[1]), .Busy(busy[1]),
        .Ready(rdy[1])
`ifdef MEM_FAULT_EN
        , .Fault(flt[1])
`endif
    );

    mem_responder #(.ADDR_W(9), .DEPTH(DEPTH), .WAIT_STATES(3)) d3 (
        .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write),
        .MAR_q(MAR_q), .MDR_q(MDR_q), .Mdatain(mdat[2]), .Busy(busy[2]),
        .Ready(rdy[2])
`ifdef MEM_FAULT_EN
        , .Fault(flt[2])
`endif
    );

    // Model address mapping: wraps to DEPTH words unless fault checking is on.
    function automatic bit is_oob(input logic [31:0] mar);
`ifdef MEM_FAULT_EN
        return mar >= 32'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mk_mar(input int unsigned addr);
`ifdef MEM_FAULT_EN
        return 32'(addr);
`else
        return ($urandom() & 32'hFFFF_FE00) | 32'(addr);
`endif
    endfunction

    // One single-cycle strobe; checks latency, pulse count, Busy length, data.
    task automatic do_access(input bit wr, input bit rd, input logic [31:0] mar,
                             input logic [31:0] data);
        int          rdy_at  [3];
        int          rdy_cnt [3];
        int          busy_cnt[3];
        logic [31:0] mdat_at [3];
        bit          oob;
        int          idx;
`ifdef MEM_FAULT_EN
        logic        flt_at  [3];
        logic        flt_c0  [3];
`endif
        oob = is_oob(mar);
        idx = int'(mar % 32'(DEPTH));
        for (int i = 0; i < 3; i++) begin
            rdy_at[i] = -1; rdy_cnt[i] = 0; busy_cnt[i] = 0; mdat_at[i] = 'x;
        end
        Write = wr; Read = rd; MAR_q = mar; MDR_q = data;
        for (int c = 0; c < 7; c++) begin
            @(posedge Clock); #1;
            if (c == 0) begin Read = 1'b0; Write = 1'b0; end
            for (int i = 0; i < 3; i++) begin
                if (busy[i]) busy_cnt[i]++;
                if (rdy[i]) begin
                    rdy_cnt[i]++; rdy_at[i] = c; mdat_at[i] = mdat[i];
`ifdef MEM_FAULT_EN
                    flt_at[i] = flt[i];
`endif
                end
`ifdef MEM_FAULT_EN
                if (c == 0) flt_c0[i] = flt[i];
`endif
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (wr) begin
                if (!oob) ref_mem[i][idx] = data;
            end else begin
                exp_mdat[i] = oob ? 32'd0 : ref_mem[i][idx];
            end
            checks++;
            if (rdy_at[i] !== 1 + ws_of[i]) begin
                errors++;
                $display("FAIL access_latency ws=%0d addr=%h: ready after edge N+%0d, expected N+%0d",
                         ws_of[i], mar, rdy_at[i], 1 + ws_of[i]);
            end
            checks++;
            if (rdy_cnt[i] !== 1) begin
                errors++;
                $display("FAIL access_ready_count ws=%0d: got %0d pulses, expected 1", ws_of[i], rdy_cnt[i]);
            end
            checks++;
            if (busy_cnt[i] !== 1 + ws_of[i]) begin
                errors++;
                $display("FAIL access_busy_len ws=%0d: got %0d cycles, expected %0d",
                         ws_of[i], busy_cnt[i], 1 + ws_of[i]);
            end
            checks++;
            if (mdat_at[i] !== exp_mdat[i]) begin
                errors++;
                $display("FAIL access_mdatain ws=%0d wr=%0d addr=%h: got %h, expected %h",
                         ws_of[i], wr, mar, mdat_at[i], exp_mdat[i]);
            end
`ifdef MEM_FAULT_EN
            checks++;
            if (flt_c0[i] !== 1'b0) begin
                errors++;
                $display("FAIL fault_clear_on_accept ws=%0d: got %b, expected 0", ws_of[i], flt_c0[i]);
            end
            checks++;
            if (flt_at[i] !== oob) begin
                errors++;
                $display("FAIL fault_flag ws=%0d addr=%h: got %b, expected %b", ws_of[i], mar, flt_at[i], oob);
            end
`endif
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int j = 0; j < DEPTH; j++) begin
            v = 32'hA500_0000 ^ (32'(j) * 32'h0001_0203);
            d0.ram_q[j] <= v;
            d1.ram_q[j] <= v;
            d3.ram_q[j] <= v;
            for (int i = 0; i < 3; i++) ref_mem[i][j] = v;
        end
        Clear = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mdat[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset_mdatain ws=%0d: got %h, expected 0", ws_of[i], mdat[i]);
            end
            checks++;
            if (busy[i] !== 1'b0 || rdy[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy_ready ws=%0d: got busy=%b ready=%b, expected 0/0",
                         ws_of[i], busy[i], rdy[i]);
            end
`ifdef MEM_FAULT_EN
            checks++;
            if (flt[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_fault ws=%0d: got %b, expected 0", ws_of[i], flt[i]);
            end
`endif
            exp_mdat[i] = 32'd0;
        end
        Clear = 1'b0;
        do_access(1'b0, 1'b1, mk_mar(7), 32'd0);
        do_access(1'b0, 1'b1, mk_mar(511), 32'd0);
    endtask

    task automatic test_write_read();
        do_access(1'b1, 1'b0, 32'd85, 32'd15);
        do_access(1'b0, 1'b1, 32'd85, 32'd0);
        do_access(1'b1, 1'b1, 32'd86, 32'hCAFE_0001);
        do_access(1'b0, 1'b1, 32'd86, 32'd0);
    endtask

    task automatic test_held_read();
        int cnt [3];
        int idx;
        idx = 300;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        Read = 1'b1; MAR_q = mk_mar(300);
        for (int c = 0; c < 12; c++) begin
            @(posedge Clock); #1;
            if (c == 4) Read = 1'b0;
            for (int i = 0; i < 3; i++) if (rdy[i]) cnt[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            exp_mdat[i] = ref_mem[i][idx];
            checks++;
            if (cnt[i] !== 1) begin
                errors++;
                $display("FAIL held_read_pulses ws=%0d: got %0d, expected 1", ws_of[i], cnt[i]);
            end
            checks++;
            if (mdat[i] !== exp_mdat[i]) begin
                errors++;
                $display("FAIL held_read_data ws=%0d: got %h, expected %h", ws_of[i], mdat[i], exp_mdat[i]);
            end
        end
    endtask

    // Second rising Read g edges after the first: taken only once the unit is idle again.
    task automatic test_second_strobe(input int g, input int a1, input int a2);
        int cnt [3];
        bit taken;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        Read = 1'b1; MAR_q = mk_mar(a1);
        for (int c = 0; c < 14; c++) begin
            @(posedge Clock); #1;
            if (c == 0) Read = 1'b0;
            if (c == g - 1) begin Read = 1'b1; MAR_q = mk_mar(a2); end
            if (c == g) Read = 1'b0;
            for (int i = 0; i < 3; i++) if (rdy[i]) cnt[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            taken = (g >= 2 + ws_of[i]);
            exp_mdat[i] = taken ? ref_mem[i][a2] : ref_mem[i][a1];
            checks++;
            if (cnt[i] !== (taken ? 2 : 1)) begin
                errors++;
                $display("FAIL second_strobe_pulses g=%0d ws=%0d: got %0d, expected %0d",
                         g, ws_of[i], cnt[i], taken ? 2 : 1);
            end
            checks++;
            if (mdat[i] !== exp_mdat[i]) begin
                errors++;
                $display("FAIL second_strobe_data g=%0d ws=%0d: got %h, expected %h",
                         g, ws_of[i], mdat[i], exp_mdat[i]);
            end
        end
    endtask

    // Clear is sampled on edge N+2; only an access already finished by then survives.
    task automatic test_clear_mid_wait();
        int  cnt [3];
        bit  done;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        Write = 1'b1; MAR_q = mk_mar(10); MDR_q = 32'hDEAD_BEEF;
        for (int c = 0; c < 8; c++) begin
            @(posedge Clock); #1;
            for (int i = 0; i < 3; i++) if (rdy[i]) cnt[i]++;
            if (c == 0) Write = 1'b0;
            if (c == 1) Clear = 1'b1;
            if (c == 2) Clear = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            done = (1 + ws_of[i] < 2);
            if (done) ref_mem[i][10] = 32'hDEAD_BEEF;
            exp_mdat[i] = 32'd0;
            checks++;
            if (cnt[i] !== (done ? 1 : 0)) begin
                errors++;
                $display("FAIL clear_ready_pulses ws=%0d: got %0d, expected %0d", ws_of[i], cnt[i], done ? 1 : 0);
            end
            checks++;
            if (busy[i] !== 1'b0 || mdat[i] !== 32'd0) begin
                errors++;
                $display("FAIL clear_outputs ws=%0d: got busy=%b mdat=%h, expected 0/0",
                         ws_of[i], busy[i], mdat[i]);
            end
        end
        do_access(1'b0, 1'b1, mk_mar(10), 32'd0);
    endtask

    task automatic test_random(input int n);
        int unsigned op;
        int unsigned addr;
        for (int k = 0; k < n; k++) begin
            op   = $urandom_range(0, 2);
            addr = $urandom_range(0, DEPTH - 1);
            do_access(op != 0, op != 1, mk_mar(addr), $urandom());
        end
    endtask

`ifdef MEM_FAULT_EN
    task automatic test_fault();
        do_access(1'b1, 1'b0, 32'd600, 32'h1234_5678);
        do_access(1'b0, 1'b1, 32'd600, 32'd0);
        do_access(1'b0, 1'b1, 32'd88, 32'd0);
        do_access(1'b0, 1'b1, 32'h8000_0005, 32'd0);
        do_access(1'b1, 1'b0, 32'd85, 32'd99);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_held_read();
        test_second_strobe(2, 40, 41);
        test_second_strobe(3, 42, 43);
        test_second_strobe(5, 44, 45);
        test_clear_mid_wait();
`ifdef MEM_FAULT_EN
        test_fault();
`endif
        test_random(30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
